// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: timed sequencer for an HD44780-compatible character LCD in
// 4-bit mode. Runs the power-on init nibbles and the configuration bytes on
// its own, then accepts one command/data byte at a time over valid/ready and
// sends it as a high nibble then a low nibble with E setup/pulse/hold timing.
// Optional build macro LCD_CTRL_REINIT_EN adds a 'reinit' input that, when
// sampled high in IDLE without a simultaneous accept, reruns the full init.
// All outputs are registered and decoded from the next state, so they line
// up exactly with the state they belong to.
// Each timed state lasts its parameter value in cycles. T_POWERUP must be at
// least 2 and the other timing parameters at least 1.
module lcd_char_ctrl #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_HOLD    = 1,
  parameter int T_GAP     = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_byte,
`ifdef LCD_CTRL_REINIT_EN
  input  logic       reinit,
`endif
  output logic       req_ready,
  output logic       init_done,
  output logic       sf_e,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic       d,
  output logic       c,
  output logic       b,
  output logic       a
);

  localparam logic [19:0] W_POWERUP = 20'(T_POWERUP);
  localparam logic [19:0] W_INIT1   = 20'(T_INIT1);
  localparam logic [19:0] W_INIT2   = 20'(T_INIT2);
  localparam logic [19:0] W_CMD     = 20'(T_CMD);
  localparam logic [19:0] W_CLEAR   = 20'(T_CLEAR);
  localparam logic [19:0] W_SETUP   = 20'(T_SETUP);
  localparam logic [19:0] W_PULSE   = 20'(T_PULSE);
  localparam logic [19:0] W_HOLD    = 20'(T_HOLD);
  localparam logic [19:0] W_GAP     = 20'(T_GAP);

  localparam logic [3:0] S_PWR_WAIT   = 4'd0;
  localparam logic [3:0] S_INIT_SETUP = 4'd1;
  localparam logic [3:0] S_INIT_PULSE = 4'd2;
  localparam logic [3:0] S_INIT_HOLD  = 4'd3;
  localparam logic [3:0] S_INIT_WAIT  = 4'd4;
  localparam logic [3:0] S_LOAD       = 4'd5;
  localparam logic [3:0] S_HI_SETUP   = 4'd6;
  localparam logic [3:0] S_HI_PULSE   = 4'd7;
  localparam logic [3:0] S_HI_HOLD    = 4'd8;
  localparam logic [3:0] S_GAP        = 4'd9;
  localparam logic [3:0] S_LO_SETUP   = 4'd10;
  localparam logic [3:0] S_LO_PULSE   = 4'd11;
  localparam logic [3:0] S_LO_HOLD    = 4'd12;
  localparam logic [3:0] S_EXEC_WAIT  = 4'd13;
  localparam logic [3:0] S_INIT_FIN   = 4'd14;
  localparam logic [3:0] S_IDLE       = 4'd15;

  logic [3:0]  state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [1:0]  init_idx, init_idx_nx;
  logic [1:0]  cfg_idx, cfg_idx_nx;
  logic [7:0]  data_q, data_nx;
  logic        rs_q, rs_nx;
  logic        done_nx;
  logic        cnt_last;
  logic        reinit_req;
  logic        e_nx;
  logic        rs_out_nx;
  logic [3:0]  nib_nx;

`ifdef LCD_CTRL_REINIT_EN
  assign reinit_req = reinit;
`else
  assign reinit_req = 1'b0;
`endif

  // Counter is loaded with the state length on entry; the last cycle is at 1.
  assign cnt_last = (cnt <= 20'd1);

  // Init nibble sequence: three 0x3 wake-ups, then 0x2 to select 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd3:    nib = 4'h2;
      default: nib = 4'h3;
    endcase
    return nib;
  endfunction

  // Wait that follows each init nibble.
  function automatic logic [19:0] init_wait(input logic [1:0] idx);
    logic [19:0] w;
    case (idx)
      2'd0:    w = W_INIT1;
      2'd1:    w = W_INIT2;
      default: w = W_CMD;
    endcase
    return w;
  endfunction

  // Configuration: function set 4-bit/2-line, entry mode, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] v;
    case (idx)
      2'd0:    v = 8'h28;
      2'd1:    v = 8'h06;
      2'd2:    v = 8'h0C;
      default: v = 8'h01;
    endcase
    return v;
  endfunction

  // Clear and Return Home need the long execution time.
  function automatic logic [19:0] exec_wait(input logic rs_bit, input logic [7:0] v);
    logic [19:0] w;
    if (!rs_bit && (v == 8'h01 || v == 8'h02 || v == 8'h03)) begin
      w = W_CLEAR;
    end else begin
      w = W_CMD;
    end
    return w;
  endfunction

  // Next-state, wait-counter and latched-byte logic for the sequencer.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    init_idx_nx = init_idx;
    cfg_idx_nx  = cfg_idx;
    data_nx     = data_q;
    rs_nx       = rs_q;
    done_nx     = init_done;
    case (state)
      S_PWR_WAIT: begin
        // Entered with the counter cleared; the first cycle loads it.
        if (cnt == 20'd0) begin
          cnt_nx = W_POWERUP - 20'd1;
        end else if (cnt == 20'd1) begin
          state_nx    = S_INIT_SETUP;
          cnt_nx      = W_SETUP;
          init_idx_nx = 2'd0;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_INIT_SETUP: begin
        if (cnt_last) begin
          state_nx = S_INIT_PULSE;
          cnt_nx   = W_PULSE;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_INIT_PULSE: begin
        if (cnt_last) begin
          state_nx = S_INIT_HOLD;
          cnt_nx   = W_HOLD;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_INIT_HOLD: begin
        if (cnt_last) begin
          state_nx = S_INIT_WAIT;
          cnt_nx   = init_wait(init_idx);
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_INIT_WAIT: begin
        if (cnt_last && init_idx == 2'd3) begin
          state_nx   = S_LOAD;
          cnt_nx     = 20'd0;
          cfg_idx_nx = 2'd0;
        end else if (cnt_last) begin
          state_nx    = S_INIT_SETUP;
          cnt_nx      = W_SETUP;
          init_idx_nx = init_idx + 2'd1;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_LOAD: begin
        // Configuration bytes come from the table; requests were latched at accept.
        state_nx = S_HI_SETUP;
        cnt_nx   = W_SETUP;
        if (!init_done) begin
          data_nx = cfg_byte(cfg_idx);
          rs_nx   = 1'b0;
        end else begin
          data_nx = data_q;
          rs_nx   = rs_q;
        end
      end
      S_HI_SETUP: begin
        if (cnt_last) begin
          state_nx = S_HI_PULSE;
          cnt_nx   = W_PULSE;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_HI_PULSE: begin
        if (cnt_last) begin
          state_nx = S_HI_HOLD;
          cnt_nx   = W_HOLD;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_HI_HOLD: begin
        if (cnt_last) begin
          state_nx = S_GAP;
          cnt_nx   = W_GAP;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_GAP: begin
        if (cnt_last) begin
          state_nx = S_LO_SETUP;
          cnt_nx   = W_SETUP;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_LO_SETUP: begin
        if (cnt_last) begin
          state_nx = S_LO_PULSE;
          cnt_nx   = W_PULSE;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_LO_PULSE: begin
        if (cnt_last) begin
          state_nx = S_LO_HOLD;
          cnt_nx   = W_HOLD;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_LO_HOLD: begin
        if (cnt_last) begin
          state_nx = S_EXEC_WAIT;
          cnt_nx   = exec_wait(rs_q, data_q);
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_EXEC_WAIT: begin
        if (cnt_last && init_done) begin
          state_nx = S_IDLE;
          cnt_nx   = 20'd0;
        end else if (cnt_last && cfg_idx == 2'd3) begin
          state_nx = S_INIT_FIN;
          cnt_nx   = 20'd0;
          done_nx  = 1'b1;
        end else if (cnt_last) begin
          state_nx   = S_LOAD;
          cnt_nx     = 20'd0;
          cfg_idx_nx = cfg_idx + 2'd1;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      S_INIT_FIN: begin
        state_nx = S_IDLE;
        cnt_nx   = 20'd0;
      end
      S_IDLE: begin
        // A pending request always wins over reinit.
        cnt_nx = 20'd0;
        if (req_valid) begin
          state_nx = S_LOAD;
          data_nx  = req_byte;
          rs_nx    = req_rs;
        end else if (reinit_req) begin
          state_nx = S_PWR_WAIT;
          done_nx  = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_PWR_WAIT;
        cnt_nx   = 20'd0;
        done_nx  = 1'b0;
      end
    endcase
  end

  // LCD pin values for the state about to be entered.
  always_comb begin
    e_nx      = 1'b0;
    rs_out_nx = 1'b0;
    nib_nx    = 4'h0;
    case (state_nx)
      S_INIT_SETUP, S_INIT_HOLD: begin
        nib_nx = init_nibble(init_idx_nx);
      end
      S_INIT_PULSE: begin
        nib_nx = init_nibble(init_idx_nx);
        e_nx   = 1'b1;
      end
      S_HI_SETUP, S_HI_HOLD: begin
        nib_nx    = data_nx[7:4];
        rs_out_nx = rs_nx;
      end
      S_HI_PULSE: begin
        nib_nx    = data_nx[7:4];
        rs_out_nx = rs_nx;
        e_nx      = 1'b1;
      end
      S_GAP: begin
        rs_out_nx = rs_nx;
      end
      S_LO_SETUP, S_LO_HOLD: begin
        nib_nx    = data_nx[3:0];
        rs_out_nx = rs_nx;
      end
      S_LO_PULSE: begin
        nib_nx    = data_nx[3:0];
        rs_out_nx = rs_nx;
        e_nx      = 1'b1;
      end
      default: begin
        nib_nx = 4'h0;
      end
    endcase
  end

  // State, counter and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_PWR_WAIT;
      cnt          <= 20'd0;
      init_idx     <= 2'd0;
      cfg_idx      <= 2'd0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      init_done    <= 1'b0;
      req_ready    <= 1'b0;
      e            <= 1'b0;
      rs           <= 1'b0;
      rw           <= 1'b0;
      sf_e         <= 1'b1;
      {d, c, b, a} <= 4'h0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      init_idx     <= init_idx_nx;
      cfg_idx      <= cfg_idx_nx;
      data_q       <= data_nx;
      rs_q         <= rs_nx;
      init_done    <= done_nx;
      req_ready    <= (state_nx == S_IDLE);
      e            <= e_nx;
      rs           <= rs_out_nx;
      rw           <= 1'b0;
      sf_e         <= 1'b1;
      {d, c, b, a} <= nib_nx;
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Self-checking bench for lcd_char_ctrl. Each issued byte pushes its expected
// E pulses and accept-to-ready latency into queues; a monitor compares them
// with what the LCD pins actually show.
module tb_lcd_char_ctrl;

  localparam int P_POWERUP = 20;
  localparam int P_INIT1   = 10;
  localparam int P_INIT2   = 5;
  localparam int P_CMD     = 4;
  localparam int P_CLEAR   = 8;
  localparam int P_SETUP   = 2;
  localparam int P_PULSE   = 12;
  localparam int P_HOLD    = 1;
  localparam int P_GAP     = 50;
  localparam int BUDGET    = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_byte = 8'h00;
`ifdef LCD_CTRL_REINIT_EN
  logic       reinit = 1'b0;
`endif
  logic req_ready, init_done, sf_e, e, rs, rw, d, c, b, a;

  lcd_char_ctrl #(
    .T_POWERUP(P_POWERUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2),
    .T_CMD(P_CMD), .T_CLEAR(P_CLEAR), .T_SETUP(P_SETUP),
    .T_PULSE(P_PULSE), .T_HOLD(P_HOLD), .T_GAP(P_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
    .req_byte(req_byte),
`ifdef LCD_CTRL_REINIT_EN
    .reinit(reinit),
`endif
    .req_ready(req_ready), .init_done(init_done), .sf_e(sf_e), .e(e),
    .rs(rs), .rw(rw), .d(d), .c(c), .b(b), .a(a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic       rsv;
    int         gap;  // idle cycles since previous E fall, -1 = not checked
  } pulse_t;

  pulse_t exp_q[$];
  int     lat_q[$];
  int     checks = 0;
  int     errors = 0;
  int     sent = 0;
  int     accepts = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference model: execution time from the command rules.
  function automatic int exec_cycles(input logic rsv, input logic [7:0] v);
    if (!rsv && v >= 8'h01 && v <= 8'h03) return P_CLEAR;
    return P_CMD;
  endfunction

  task automatic push_pulse(input logic [3:0] nib, input logic rsv, input int gap);
    pulse_t p;
    p.nib = nib;
    p.rsv = rsv;
    p.gap = gap;
    exp_q.push_back(p);
  endtask

  task automatic expect_byte(input logic rsv, input logic [7:0] v);
    push_pulse(v[7:4], rsv, -1);
    push_pulse(v[3:0], rsv, P_HOLD + P_GAP + P_SETUP);
  endtask

  task automatic expect_init();
    push_pulse(4'h3, 1'b0, -1);
    push_pulse(4'h3, 1'b0, P_HOLD + P_INIT1 + P_SETUP);
    push_pulse(4'h3, 1'b0, P_HOLD + P_INIT2 + P_SETUP);
    push_pulse(4'h2, 1'b0, P_HOLD + P_CMD + P_SETUP);
    expect_byte(1'b0, 8'h28);
    expect_byte(1'b0, 8'h06);
    expect_byte(1'b0, 8'h0C);
    expect_byte(1'b0, 8'h01);
  endtask

  // Called at a negedge; leaves rst_n released at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_e", int'(e), 0);
    chk("rst_rs", int'(rs), 0);
    chk("rst_rw", int'(rw), 0);
    chk("rst_nibble", int'({d, c, b, a}), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_sf_e", int'(sf_e), 1);
    exp_q.delete();
    lat_q.delete();
    expect_init();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_timeout"}, int'(n < BUDGET), 1);
  endtask

  task automatic send(input logic rsv, input logic [7:0] v, input bit hold_valid);
    req_valid = 1'b1;
    req_rs    = rsv;
    req_byte  = v;
    wait_ready("accept");
    if (req_ready === 1'b1) begin
      expect_byte(rsv, v);
      lat_q.push_back(1 + 2 * (P_SETUP + P_PULSE + P_HOLD) + P_GAP + exec_cycles(rsv, v));
      sent++;
    end
    @(negedge clk);
    req_valid = hold_valid;
    req_rs    = 1'($urandom);
    req_byte  = 8'($urandom);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int         cyc = 0;
    int         w = 0;
    int         gap = 0;
    int         fall_cyc = 0;
    int         done_cyc = 0;
    int         acc_cyc = 0;
    bit         in_pulse = 1'b0;
    bit         stable = 1'b1;
    bit         prev_ready = 1'b0;
    bit         prev_done = 1'b0;
    logic [3:0] pnib = 4'h0;
    logic [3:0] last_nib = 4'h0;
    logic       prs = 1'b0;
    logic       last_rs = 1'b0;
    pulse_t     p;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        in_pulse   = 1'b0;
        prev_ready = 1'b0;
        prev_done  = 1'b0;
        last_nib   = 4'h0;
        last_rs    = 1'b0;
      end else begin
        if (req_valid && prev_ready) begin
          accepts++;
          acc_cyc = cyc;
        end
        if (init_done && !prev_done) done_cyc = cyc;
        if (req_ready && !prev_ready) begin
          chk("idle_pins", int'({e, rs, rw, sf_e, d, c, b, a}), 16);
          if (lat_q.size() > 0) begin
            chk("accept_to_ready", cyc - acc_cyc, lat_q.pop_front());
          end else begin
            chk("init_done_lead", cyc - done_cyc, 1);
            chk("init_pulses_left", exp_q.size(), 0);
          end
        end
        if (e && !in_pulse) begin
          in_pulse = 1'b1;
          w        = 1;
          pnib     = {d, c, b, a};
          prs      = rs;
          gap      = cyc - fall_cyc;
          stable   = (last_nib == pnib) && (last_rs == prs);
        end else if (e && in_pulse) begin
          w++;
          if ({d, c, b, a} != pnib || rs != prs) stable = 1'b0;
        end else if (!e && in_pulse) begin
          in_pulse = 1'b0;
          fall_cyc = cyc;
          if ({d, c, b, a} != pnib || rs != prs) stable = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got nibble %0d rs %0d, expected no pulse", pnib, prs);
          end else begin
            p = exp_q.pop_front();
            chk("pulse_nibble", int'(pnib), int'(p.nib));
            chk("pulse_rs", int'(prs), int'(p.rsv));
            chk("pulse_width", w, P_PULSE);
            if (p.gap >= 0) chk("pulse_gap", gap, p.gap);
            chk("pulse_setup_hold", int'(stable), 1);
          end
        end
        prev_ready = req_ready;
        prev_done  = init_done;
        last_nib   = {d, c, b, a};
        last_rs    = rs;
      end
    end
  end

  // Stimulus: directed cases, then random bytes, then reset mid-transfer.
  initial begin
    logic [7:0] v;
    logic       r;
    int         n;
    do_reset();
    wait_ready("init");
    send(1'b1, 8'h48, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'hC0, 1'b0);
    send(1'b1, 8'h48, 1'b1);
    send(1'b1, 8'h69, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0;
        v = 8'($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(r, v, 1'b0);
    end
    send(1'b1, 8'h5A, 1'b0);
    n = 0;
    while (e !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("hi_pulse_wait", int'(n < BUDGET), 1);
    do_reset();
    wait_ready("reinit_after_reset");
    send(1'b1, 8'h21, 1'b0);
`ifdef LCD_CTRL_REINIT_EN
    wait_ready("before_reinit");
    expect_init();
    reinit = 1'b1;
    @(posedge clk);
    #1;
    chk("reinit_init_done", int'(init_done), 0);
    chk("reinit_req_ready", int'(req_ready), 0);
    @(negedge clk);
    reinit = 1'b0;
    wait_ready("after_reinit");
    send(1'b1, 8'h51, 1'b0);
    reinit = 1'b1;
    repeat (20) @(negedge clk);
    reinit = 1'b0;
`endif
    wait_ready("final");
    n = 0;
    while ((exp_q.size() != 0 || lat_q.size() != 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", int'(n < BUDGET), 1);
    chk("accept_count", accepts, sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
